// File: rtl/mseq_pkg.sv
// Shared types and the single feedback step used by the m-sequence scheduler.
// step_fn works on a fixed wide container so any channel WIDTH up to MAX_W reuses it.
package mseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_COMMIT
  } fsm_e;

  localparam int DEF_WIDTH = 4;
  localparam int MAX_W     = 32;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {parity, next_state}; state/taps must be zero above bit width-1.
  function automatic logic [MAX_W:0] step_fn(input logic [MAX_W-1:0] state,
                                             input logic [MAX_W-1:0] taps,
                                             input int               width);
    logic             sum;
    logic [MAX_W-1:0] nxt;
    sum = ^(state & taps);
    nxt = (state >> 1) | ({{(MAX_W-1){1'b0}}, sum} << (width - 1));
    return {sum, nxt};
  endfunction

endpackage

// File: rtl/mseq_rr_arb.sv
// Combinational round-robin arbiter: search starts one past the last winner and wraps.
module mseq_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            c;
  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last) + k;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/mseq_sched.sv
// Time-shared m-sequence scheduler: per-channel state/taps, round-robin grant,
// one shared feedback evaluation in flight at a time with fixed grant-to-result latency.
module mseq_sched
  import mseq_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STEP_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]            cfg_type,
  input  logic [WIDTH-1:0]            cfg_seed,
  input  logic [CHANNELS-1:0]         req,
  output logic [CHANNELS-1:0]         grant,
  output logic                        bit_valid,
  output logic [$clog2(CHANNELS)-1:0] bit_ch,
  output logic                        bit_out,
  output logic [WIDTH-1:0]            fase_out,
  output logic                        busy,
  output logic [CHANNELS-1:0]         lockup
);

  localparam int CW    = ch_w(CHANNELS);
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] st_q;
  logic [CHANNELS-1:0][WIDTH-1:0] tp_q;
  logic [CHANNELS-1:0]            en_q;
  logic [CHANNELS-1:0]            lock_q;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    cur_q, cur_d;
  logic [CW-1:0]    ptr_q, ptr_d;

  logic [CHANNELS-1:0] arb_gnt;
  logic [CW-1:0]       arb_idx;
  logic                arb_any;

  logic [CW-1:0]    eval_ch;
  logic [WIDTH-1:0] eval_st;
  logic [WIDTH-1:0] eval_tp;
  logic [MAX_W:0]   step_res;
  logic             step_sum;
  logic [WIDTH-1:0] step_nxt;
  logic             unused_hi;

  logic commit;
  logic abort;

  logic             bit_valid_q;
  logic [CW-1:0]    bit_ch_q;
  logic             bit_out_q;
  logic [WIDTH-1:0] fase_q;

  mseq_rr_arb #(
    .N  (CHANNELS),
    .IW (CW)
  ) u_arb (
    .req  (req & en_q),
    .last (ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Shared feedback unit: the winner is evaluated directly from IDLE when STEP_CYCLES==1.
  assign eval_ch   = (fsm_q == ST_IDLE) ? arb_idx : cur_q;
  assign eval_st   = st_q[eval_ch];
  assign eval_tp   = tp_q[eval_ch];
  assign step_res  = step_fn(MAX_W'(eval_st), MAX_W'(eval_tp), WIDTH);
  assign step_sum  = step_res[MAX_W];
  assign step_nxt  = step_res[WIDTH-1:0];
  assign unused_hi = ^step_res[MAX_W-1:WIDTH];

  assign abort = cfg_we && (cfg_ch == cur_q);

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    cur_d  = cur_q;
    ptr_d  = ptr_q;
    commit = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (arb_any) begin
          cur_d = arb_idx;
          if (STEP_CYCLES == 1) begin
            fsm_d  = ST_COMMIT;
            commit = 1'b1;
          end else begin
            fsm_d = ST_EVAL;
            cnt_d = CNT_W'(STEP_CYCLES - 1);
          end
        end
      end
      ST_EVAL: begin
        cnt_d = cnt_q - 1'b1;
        if (abort) begin
          // The fresh configuration wins; the channel still loses its turn.
          fsm_d = ST_IDLE;
          ptr_d = cur_q;
        end else if (cnt_d == '0) begin
          fsm_d  = ST_COMMIT;
          commit = 1'b1;
        end
      end
      ST_COMMIT: begin
        fsm_d = ST_IDLE;
        ptr_d = cur_q;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
      cur_q <= '0;
      ptr_q <= CW'(CHANNELS - 1);
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      ptr_q <= ptr_d;
    end
  end

  // Channel table: a config write always takes priority over a step write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      tp_q   <= '0;
      en_q   <= '0;
      lock_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && (cfg_ch == CW'(i))) begin
          st_q[i]   <= cfg_seed;
          tp_q[i]   <= cfg_type;
          en_q[i]   <= (cfg_type != '0);
          lock_q[i] <= (cfg_type != '0) && (cfg_seed == '0);
        end else if (commit && (eval_ch == CW'(i))) begin
          st_q[i]   <= step_nxt;
          lock_q[i] <= en_q[i] && (step_nxt == '0);
        end
      end
    end
  end

  // Result stage: fields hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_valid_q <= 1'b0;
      bit_ch_q    <= '0;
      bit_out_q   <= 1'b0;
      fase_q      <= '0;
    end else begin
      bit_valid_q <= commit;
      if (commit) begin
        bit_ch_q  <= eval_ch;
        bit_out_q <= step_sum;
        fase_q    <= step_nxt;
      end
    end
  end

  assign grant     = (fsm_q == ST_IDLE) ? arb_gnt : '0;
  assign busy      = (fsm_q != ST_IDLE);
  assign bit_valid = bit_valid_q;
  assign bit_ch    = bit_ch_q;
  assign bit_out   = bit_out_q;
  assign fase_out  = fase_q;
  assign lockup    = lock_q;

endmodule

// File: tb/tb_mseq_sched.sv
// Scoreboard bench for mseq_sched: stimulus queues expected grants/results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mseq_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_type;
  logic [3:0] cfg_seed;
  logic [3:0] req;
  logic [3:0] grant;
  logic       bit_valid;
  logic [1:0] bit_ch;
  logic       bit_out;
  logic [3:0] fase_out;
  logic       busy;
  logic [3:0] lockup;

  mseq_sched #(.CHANNELS(4), .WIDTH(4), .STEP_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_type  (cfg_type),
    .cfg_seed  (cfg_seed),
    .req       (req),
    .grant     (grant),
    .bit_valid (bit_valid),
    .bit_ch    (bit_ch),
    .bit_out   (bit_out),
    .fase_out  (fase_out),
    .busy      (busy),
    .lockup    (lockup)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic       b;
    logic [3:0] f;
  } exp_t;

  exp_t sq[$];
  int   gq[$];
  int   gtimes[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   gcount  = 0;
  int   vcount  = 0;
  int   last_g  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req_v, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 4'b0000) begin
        gcount++;
        gtimes.push_back(cyc);
        last_g = cyc;
        if (gq.size() == 0) fail_now($sformatf("unexpected grant %b", grant));
        else begin
          int e;
          e = gq.pop_front();
          check("grant", {28'd0, grant}, {28'd0, 4'b0001 << e});
        end
      end
      if (bit_valid) begin
        vcount++;
        if (sq.size() == 0) fail_now($sformatf("unexpected bit_valid ch=%0d fase=%b", bit_ch, fase_out));
        else begin
          exp_t e;
          e = sq.pop_front();
          check("bit_ch",   {30'd0, bit_ch},   {30'd0, e.ch});
          check("bit_out",  {31'd0, bit_out},  {31'd0, e.b});
          check("fase_out", {28'd0, fase_out}, {28'd0, e.f});
          check("latency",  cyc - last_g, 3);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [3:0] tp, input logic [3:0] sd);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_type = tp;
    cfg_seed = sd;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push_res(input logic [1:0] ch, input logic [3:0] f);
    exp_t e;
    e.ch = ch;
    e.b  = f[3];
    e.f  = f;
    sq.push_back(e);
  endtask

  task automatic wait_grants(input int target);
    int t = 0;
    while (gcount < target && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) fail_now("grant wait timeout");
  endtask

  task automatic drain();
    int t = 0;
    while ((sq.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) fail_now("drain timeout");
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},     {28'd0, grant},    0);
    check({tag, "_bit_valid"}, {31'd0, bit_valid}, 0);
    check({tag, "_bit_ch"},    {30'd0, bit_ch},   0);
    check({tag, "_bit_out"},   {31'd0, bit_out},  0);
    check({tag, "_fase_out"},  {28'd0, fase_out}, 0);
    check({tag, "_busy"},      {31'd0, busy},     0);
    check({tag, "_lockup"},    {28'd0, lockup},   0);
  endtask

  logic [3:0] seq1 [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                            4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                            4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

  initial begin
    int v0;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_type = '0; cfg_seed = '0; req = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rst = 1'b0;

    // 1: ch0 full period, taps 0011 seed 0001
    cfg(2'd0, 4'b0011, 4'b0001);
    for (int i = 0; i < 15; i++) begin
      gq.push_back(0);
      push_res(2'd0, seq1[i]);
    end
    req = 4'b0001;
    wait_grants(gcount + 15);
    req = 4'b0000;
    drain();

    // 2: fresh reset, all four channels, rotation 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg(2'd0, 4'b0011, 4'b0001);
    cfg(2'd1, 4'b1001, 4'b1000);
    cfg(2'd2, 4'b0110, 4'b0011);
    cfg(2'd3, 4'b1111, 4'b0111);
    gtimes.delete();
    gq.push_back(0); push_res(2'd0, 4'b1000);
    gq.push_back(1); push_res(2'd1, 4'b1100);
    gq.push_back(2); push_res(2'd2, 4'b1001);
    gq.push_back(3); push_res(2'd3, 4'b1011);
    gq.push_back(0); push_res(2'd0, 4'b0100);
    req = 4'b1111;
    wait_grants(gcount + 5);
    req = 4'b0000;
    drain();
    if (gtimes.size() != 5) fail_now($sformatf("rotation grant count %0d", gtimes.size()));
    else for (int i = 1; i < 5; i++) check("grant_spacing", gtimes[i] - gtimes[i-1], 4);

    // 3: zero-tap channel is never granted
    cfg(2'd2, 4'b0000, 4'b0101);
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("zero_taps_busy", {31'd0, busy}, 0);
    end
    req = 4'b0000;
    tick();

    // 4: lockup channel
    cfg(2'd1, 4'b1001, 4'b0000);
    check("lockup_set", {28'd0, lockup}, {28'd0, 4'b0010});
    gq.push_back(1); push_res(2'd1, 4'b0000);
    req = 4'b0010;
    wait_grants(gcount + 1);
    req = 4'b0000;
    drain();
    check("lockup_hold", {28'd0, lockup}, {28'd0, 4'b0010});

    // 5: config write to the in-flight channel aborts the step
    gq.push_back(0);
    v0 = vcount;
    req = 4'b0001;
    wait_grants(gcount + 1);
    req = 4'b0000;
    cfg(2'd0, 4'b0011, 4'b0110);
    repeat (6) tick();
    check("abort_no_valid", vcount, v0);
    check("abort_busy", {31'd0, busy}, 0);
    gq.push_back(0); push_res(2'd0, 4'b1011);
    req = 4'b0001;
    wait_grants(gcount + 1);
    req = 4'b0000;
    drain();

    // 6: reset during EVAL
    gq.push_back(0);
    v0 = vcount;
    req = 4'b0001;
    wait_grants(gcount + 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    req = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_no_valid", vcount, v0);
    cfg(2'd1, 4'b1001, 4'b1000);
    cfg(2'd0, 4'b0011, 4'b0001);
    gq.push_back(0); push_res(2'd0, 4'b1000);
    gq.push_back(1); push_res(2'd1, 4'b1100);
    req = 4'b0011;
    wait_grants(gcount + 2);
    req = 4'b0000;
    drain();

    check("grant_queue_empty", gq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
